// File: rtl/fifo_reader.sv
// fifo_reader
//   Reads a burst of burst_len words from an upstream syn_fifo (1-cycle read
//   latency) and forwards them on a valid/ready stream through a 2-entry
//   output buffer, so full throughput is kept while never over-reading.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, burst_len     burst request and length (sampled in IDLE)
//   busy, done           burst in progress / one-cycle completion pulse
//   fifo_empty           upstream empty flag
//   fifo_data            upstream read data (valid one cycle after issue)
//   fifo_rd_cs/rd_en     upstream read strobes (identical)
//   out_valid/out_data   downstream word
//   out_ready            downstream accept
//   rd_count             words issued from the FIFO in the current/last burst
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [LEN_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  rd_cnt_reg;
  logic [LEN_WIDTH-1:0]  dlv_cnt_reg;
  logic                  in_flight_reg;
  logic [1:0]            occ_reg;
  logic [DATA_WIDTH-1:0] buf0_reg;   // oldest entry, drives out_data
  logic [DATA_WIDTH-1:0] buf1_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic       pop;
  logic       issue;
  logic       last_pop;
  logic [2:0] pending;

  assign pop = (occ_reg != 2'd0) && out_ready;

  // Words that will sit in the buffer after this edge if nothing new is
  // issued: a pop this cycle frees a slot for a same-cycle issue.
  assign pending = {1'b0, occ_reg} + {2'b00, in_flight_reg} - {2'b00, pop};

  assign issue = (state_reg == RUN) && !fifo_empty &&
                 (rd_cnt_reg < len_reg) && (pending < 3'd2);

  assign last_pop = pop && (dlv_cnt_reg == len_reg - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      rd_cnt_reg    <= '0;
      dlv_cnt_reg   <= '0;
      in_flight_reg <= 1'b0;
      occ_reg       <= 2'd0;
      buf0_reg      <= '0;
      buf1_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // Data for an issue made on the previous edge is valid now.
      in_flight_reg <= issue;
      if (issue) rd_cnt_reg <= rd_cnt_reg + LEN_WIDTH'(1);
      if (pop) dlv_cnt_reg <= dlv_cnt_reg + LEN_WIDTH'(1);

      case ({in_flight_reg, pop})
        2'b10: begin
          if (occ_reg == 2'd0) buf0_reg <= fifo_data;
          else                 buf1_reg <= fifo_data;
          occ_reg <= occ_reg + 2'd1;
        end
        2'b01: begin
          buf0_reg <= buf1_reg;
          occ_reg  <= occ_reg - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: occupancy unchanged, queue shifts.
          if (occ_reg == 2'd1) begin
            buf0_reg <= fifo_data;
          end else begin
            buf0_reg <= buf1_reg;
            buf1_reg <= fifo_data;
          end
        end
        default: ;
      endcase

      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            len_reg     <= burst_len;
            rd_cnt_reg  <= '0;
            dlv_cnt_reg <= '0;
            if (burst_len != '0) begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_pop) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign fifo_rd_cs = issue;
  assign fifo_rd_en = issue;
  assign out_valid  = (occ_reg != 2'd0);
  assign out_data   = buf0_reg;
  assign rd_count   = rd_cnt_reg;

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: cycle-exact vector table for a basic burst and a
// zero-length burst, then scoreboarded burst sequences for the stall, restart
// and reset corner cases. A behavioural syn_fifo with 1-cycle latency feeds it.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        busy, done;
  logic        fifo_empty;
  logic [7:0]  fifo_data = '0;
  logic        fifo_rd_cs, fifo_rd_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [15:0] rd_count;

  int errors = 0;
  int checks = 0;

  // Behavioural upstream FIFO
  logic [7:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int next_val = 8'h40;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_cs && fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_cs(fifo_rd_cs), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .rd_count(rd_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic push_new(input int n);
    for (int k = 0; k < n; k++) begin
      push_word(next_val[7:0]);
      next_val++;
    end
  endtask

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        ready;
    logic        busy;
    logic        done;
    logic        valid;
    logic [7:0]  data;
    logic        rd;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic s, input logic [15:0] l, input logic r,
                              input logic b, input logic d, input logic v,
                              input logic [7:0] dat, input logic rd, input logic [15:0] c);
    vec_t x;
    x.start = s; x.len = l; x.ready = r; x.busy = b; x.done = d;
    x.valid = v; x.data = dat; x.rd = rd; x.cnt = c;
    return x;
  endfunction

  // Runs one burst with a scoreboard on the delivered words.
  //   mode 0: out_ready always 1, mode 1: toggles 1/0
  //   push_at/push_n: write push_n words into the FIFO at loop cycle push_at
  //   restart_at: pulse start with burst_len=9 at that loop cycle
  //   rst_after: assert reset once that many words have been delivered
  task automatic run_burst(input string tag, input int len, input int mode,
                           input int push_at, input int push_n,
                           input int restart_at, input int rst_after);
    int  exp_idx;
    int  got = 0;
    int  dones = 0;
    int  cyc = 0;
    bit  fin = 0;
    bit  aborted = 0;
    exp_idx = rd_ptr;
    @(negedge clk);
    start = 1'b1; burst_len = 16'(len); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 300) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (cyc == push_at) push_new(push_n);
      if (cyc == restart_at) begin start = 1'b1; burst_len = 16'd9; end
      else start = 1'b0;
      #1;
      if (fifo_empty) check({tag, "_no_issue_when_empty"}, 32'(fifo_rd_en), 32'd0);
      check({tag, "_outstanding_le2"}, 32'((int'(rd_count) - got) <= 2), 32'd1);
      if (out_valid && out_ready) begin
        check({tag, "_data"}, 32'(out_data), 32'(mem[exp_idx]));
        exp_idx++;
        got++;
      end
      if (done) begin dones++; fin = 1; end
      if (rst_after >= 0 && got == rst_after) begin
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_done"}, 32'(done), 32'd0);
        check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rst_rd"}, 32'({fifo_rd_cs, fifo_rd_en}), 32'd0);
        check({tag, "_rst_count"}, 32'(rd_count), 32'd0);
        check({tag, "_rst_data"}, 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!aborted) begin
      check({tag, "_done_seen"}, 32'(fin), 32'd1);
      check({tag, "_words"}, 32'(got), 32'(len));
      check({tag, "_rd_count"}, 32'(rd_count), 32'(len));
      @(negedge clk);
      #1;
      check({tag, "_done_single"}, 32'(done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      $display("burst %s len=%0d delivered=%0d rd_count=%0d", tag, len, got, rd_count);
    end else begin
      $display("burst %s len=%0d aborted by reset after %0d words", tag, len, got);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1, 4, 1,  0, 0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 0, 1,  1, 0, 0, 8'h00, 1, 0);
    vecs[2]  = mk(0, 0, 1,  1, 0, 0, 8'h00, 1, 1);
    vecs[3]  = mk(0, 0, 1,  1, 0, 1, 8'h07, 1, 2);
    vecs[4]  = mk(0, 0, 1,  1, 0, 1, 8'h08, 1, 3);
    vecs[5]  = mk(0, 0, 1,  1, 0, 1, 8'h09, 0, 4);
    vecs[6]  = mk(0, 0, 1,  1, 0, 1, 8'h0A, 0, 4);
    vecs[7]  = mk(0, 0, 1,  0, 1, 0, 8'h00, 0, 4);
    vecs[8]  = mk(0, 0, 1,  0, 0, 0, 8'h00, 0, 4);
    vecs[9]  = mk(1, 0, 1,  0, 0, 0, 8'h00, 0, 4);
    vecs[10] = mk(0, 0, 1,  0, 1, 0, 8'h00, 0, 0);
    vecs[11] = mk(0, 0, 1,  0, 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < 8; i++) push_word(8'(8'h07 + i));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_rd", 32'({fifo_rd_cs, fifo_rd_en}), 32'd0);
    check("reset_count", 32'(rd_count), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);

    // Cycle-exact table: burst of 4 then burst of 0
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      start = vecs[i].start; burst_len = vecs[i].len; out_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
      check($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].rd));
      check($sformatf("vec%0d_rd_cs", i), 32'(fifo_rd_cs), 32'(vecs[i].rd));
      check($sformatf("vec%0d_rd_count", i), 32'(rd_count), 32'(vecs[i].cnt));
      $display("vec %0d start=%0b len=%0d busy=%0b done=%0b valid=%0b data=%02h rd=%0b cnt=%0d",
               i, start, burst_len, busy, done, out_valid, out_data, fifo_rd_en, rd_count);
    end
    start = 1'b0;
    check("fifo_words_left", 32'(wr_ptr - rd_ptr), 32'd4);

    push_new(8);                                  // 12 words available
    run_burst("toggle6", 6, 1, -1, 0, -1, -1);    // leaves 6
    run_burst("restart5", 5, 0, -1, 0, 2, -1);    // leaves 1
    check("fifo_words_left2", 32'(wr_ptr - rd_ptr), 32'd1);
    run_burst("emptystall3", 3, 0, 10, 2, -1, -1);
    check("fifo_words_left3", 32'(wr_ptr - rd_ptr), 32'd0);
    push_new(10);
    run_burst("reset5", 5, 0, -1, 0, -1, 2);
    run_burst("after_rst2", 2, 0, -1, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
